// File: rtl/mc_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_cpu_pkg
// Brief    : Shared encodings for the multi-cycle MIPS-subset CPU (opcodes,
//            functs, control FSM states, ALUOp/PCSource/ALUSrcB selects).
// Revision : 1.0 - initial release
// ============================================================================
package mc_cpu_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [5:0] c_FN_SLL   = 6'b000000;
    localparam logic [5:0] c_FN_SRL   = 6'b000010;
    localparam logic [5:0] c_FN_JR    = 6'b001000;
    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    typedef enum logic [3:0] {
        ST_IF       = 4'd0,
        ST_ID       = 4'd1,
        ST_EXE_R    = 4'd2,
        ST_EXE_I    = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_WB_I     = 4'd8,
        ST_WB_LW    = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_JAL      = 4'd12,
        ST_JR       = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_SUB    = 2'b01,
        ALUOP_FUNCT  = 2'b10,
        ALUOP_OPCODE = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        PCSRC_PC4    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RS     = 2'b11
    } pcsrc_t;

    typedef enum logic [1:0] {
        SRCB_RT      = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SL2 = 2'b11
    } alusrcb_t;

    // Last state of every instruction that retires
    function automatic logic is_final_state(input state_t s);
        return (s == ST_WB_R)   || (s == ST_WB_I) || (s == ST_WB_LW) ||
               (s == ST_MEM_WR) || (s == ST_BRANCH) || (s == ST_JUMP) ||
               (s == ST_JAL)    || (s == ST_JR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm_if
// Brief    : Decode inputs and control strobes between the main control FSM
//            (master) and the datapath (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             AddressError;
    logic             PCWrite;
    logic             PCWriteCond;
    logic [1:0]       PCSource;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             IorD;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic             RegWrite;
    logic             RegDst;
    logic             Mem_to_Reg;
    logic             jal;
    logic             branch_ne;
    logic             illegal_instr;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, zero, AddressError,
        output PCWrite, PCWriteCond, PCSource, IRWrite, MemRead, MemWrite,
               IorD, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, Mem_to_Reg,
               jal, branch_ne, illegal_instr, state, instr_count
    );

    modport slave (
        output opcode, funct, zero, AddressError,
        input  PCWrite, PCWriteCond, PCSource, IRWrite, MemRead, MemWrite,
               IorD, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst, Mem_to_Reg,
               jal, branch_ne, illegal_instr, state, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/mc_main_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mc_main_decoder
// Brief    : Combinational ID-state decode: next state and illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
module mc_main_decoder
    import mc_cpu_pkg::*;
(
    input  wire logic [5:0] opcode,
    input  wire logic [5:0] funct,
    output state_t          next_state,
    output logic            illegal
);
    always_comb begin
        next_state = ST_IF;
        illegal    = 1'b0;
        case (opcode)
            c_OP_RTYPE: begin
                case (funct)
                    c_FN_JR: next_state = ST_JR;
                    c_FN_ADD, c_FN_ADDU, c_FN_SUB, c_FN_SUBU, c_FN_AND,
                    c_FN_OR, c_FN_SLT, c_FN_SLL, c_FN_SRL:
                        next_state = ST_EXE_R;
                    default: illegal = 1'b1;
                endcase
            end
            c_OP_LW, c_OP_SW:                 next_state = ST_MEM_ADDR;
            c_OP_ADDI, c_OP_ADDIU, c_OP_ANDI,
            c_OP_ORI, c_OP_SLTI, c_OP_LUI:    next_state = ST_EXE_I;
            c_OP_BEQ, c_OP_BNE:               next_state = ST_BRANCH;
            c_OP_J:                           next_state = ST_JUMP;
            c_OP_JAL:                         next_state = ST_JAL;
            default:                          illegal    = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multi-cycle main control unit; Moore outputs per state plus a
//            retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm
    import mc_cpu_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         CNT_W       = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mc_control_fsm_if.master  ctl
);
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    state_t           w_dec_next;
    logic             w_dec_illegal;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_unused_zero;

    // Branch resolution with zero happens in the datapath via PCWriteCond
    assign w_unused_zero = ctl.zero;

    mc_main_decoder u_decoder (
        .opcode     (ctl.opcode),
        .funct      (ctl.funct),
        .next_state (w_dec_next),
        .illegal    (w_dec_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= state_t'(RESET_STATE);
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (is_final_state(r_state)) begin
                r_instr_count <= r_instr_count + c_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_next_state      = ST_IF;
        ctl.PCWrite       = 1'b0;
        ctl.PCWriteCond   = 1'b0;
        ctl.PCSource      = PCSRC_PC4;
        ctl.IRWrite       = 1'b0;
        ctl.MemRead       = 1'b0;
        ctl.MemWrite      = 1'b0;
        ctl.IorD          = 1'b0;
        ctl.ALUSrcA       = 1'b0;
        ctl.ALUSrcB       = SRCB_RT;
        ctl.ALUOp         = ALUOP_ADD;
        ctl.RegWrite      = 1'b0;
        ctl.RegDst        = 1'b0;
        ctl.Mem_to_Reg    = 1'b0;
        ctl.jal           = 1'b0;
        ctl.branch_ne     = 1'b0;
        ctl.illegal_instr = 1'b0;
        case (r_state)
            ST_IF: begin
                ctl.MemRead  = 1'b1;
                ctl.IRWrite  = 1'b1;
                ctl.ALUSrcB  = SRCB_FOUR;
                ctl.PCWrite  = 1'b1;
                w_next_state = ST_ID;
            end
            ST_ID: begin
                ctl.ALUSrcB       = SRCB_IMM_SL2;
                ctl.illegal_instr = w_dec_illegal;
                w_next_state      = w_dec_next;
            end
            ST_EXE_R: begin
                ctl.ALUSrcA  = 1'b1;
                ctl.ALUOp    = ALUOP_FUNCT;
                w_next_state = ST_WB_R;
            end
            ST_EXE_I: begin
                ctl.ALUSrcA  = 1'b1;
                ctl.ALUSrcB  = SRCB_IMM;
                ctl.ALUOp    = ALUOP_OPCODE;
                w_next_state = ST_WB_I;
            end
            ST_MEM_ADDR: begin
                ctl.ALUSrcA = 1'b1;
                ctl.ALUSrcB = SRCB_IMM;
                if (ctl.AddressError) begin
                    w_next_state = ST_IF;
                end else if (ctl.opcode == c_OP_LW) begin
                    w_next_state = ST_MEM_RD;
                end else begin
                    w_next_state = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                ctl.MemRead  = 1'b1;
                ctl.IorD     = 1'b1;
                w_next_state = ST_WB_LW;
            end
            ST_MEM_WR: begin
                ctl.MemWrite = 1'b1;
                ctl.IorD     = 1'b1;
            end
            ST_WB_R: begin
                ctl.RegWrite = 1'b1;
                ctl.RegDst   = 1'b1;
            end
            ST_WB_I: ctl.RegWrite = 1'b1;
            ST_WB_LW: begin
                ctl.RegWrite   = 1'b1;
                ctl.Mem_to_Reg = 1'b1;
            end
            ST_BRANCH: begin
                ctl.ALUSrcA     = 1'b1;
                ctl.ALUOp       = ALUOP_SUB;
                ctl.PCWriteCond = 1'b1;
                ctl.PCSource    = PCSRC_ALUOUT;
                ctl.branch_ne   = (ctl.opcode == c_OP_BNE);
            end
            ST_JUMP: begin
                ctl.PCWrite  = 1'b1;
                ctl.PCSource = PCSRC_JUMP;
            end
            ST_JAL: begin
                ctl.PCWrite  = 1'b1;
                ctl.PCSource = PCSRC_JUMP;
                ctl.jal      = 1'b1;
            end
            ST_JR: begin
                ctl.PCWrite  = 1'b1;
                ctl.PCSource = PCSRC_RS;
            end
            default: w_next_state = ST_IF;
        endcase

        // Reset silences every strobe without waiting for a clock edge
        if (reset) begin
            ctl.PCWrite       = 1'b0;
            ctl.PCWriteCond   = 1'b0;
            ctl.PCSource      = PCSRC_PC4;
            ctl.IRWrite       = 1'b0;
            ctl.MemRead       = 1'b0;
            ctl.MemWrite      = 1'b0;
            ctl.IorD          = 1'b0;
            ctl.ALUSrcA       = 1'b0;
            ctl.ALUSrcB       = SRCB_RT;
            ctl.ALUOp         = ALUOP_ADD;
            ctl.RegWrite      = 1'b0;
            ctl.RegDst        = 1'b0;
            ctl.Mem_to_Reg    = 1'b0;
            ctl.jal           = 1'b0;
            ctl.branch_ne     = 1'b0;
            ctl.illegal_instr = 1'b0;
        end
    end

    assign ctl.state       = r_state;
    assign ctl.instr_count = r_instr_count;
endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_fsm
// Brief    : Self-checking bench for mc_control_fsm against an
//            instruction-class reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;
    localparam int CW = 4;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4,
                   K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

    logic clk = 1'b0;
    logic reset;

    mc_control_fsm_if #(.CNT_W(CW)) ctl_if ();

    mc_control_fsm #(.RESET_STATE(4'd0), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (ctl_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       jal;
        logic       branch_ne;
        logic       illegal;
    } ctrl_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned model_count = 0;

    function automatic ctrl_t observed();
        return {ctl_if.PCWrite, ctl_if.PCWriteCond, ctl_if.PCSource, ctl_if.IRWrite,
                ctl_if.MemRead, ctl_if.MemWrite, ctl_if.IorD, ctl_if.ALUSrcA,
                ctl_if.ALUSrcB, ctl_if.ALUOp, ctl_if.RegWrite, ctl_if.RegDst,
                ctl_if.Mem_to_Reg, ctl_if.jal, ctl_if.branch_ne, ctl_if.illegal_instr};
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h08) return K_JR;
            if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02})
                return K_R;
            return K_ILL;
        end
        if (op == 6'h23) return K_LW;
        if (op == 6'h2b) return K_SW;
        if (op inside {6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0a, 6'h0f}) return K_I;
        if (op inside {6'h04, 6'h05}) return K_BR;
        if (op == 6'h02) return K_J;
        if (op == 6'h03) return K_JAL;
        return K_ILL;
    endfunction

    // Expected strobes for each numbered state of the control sequence
    function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] op, input bit ill);
        ctrl_t c = '0;
        case (st)
            0:  begin c.mem_read = 1; c.ir_write = 1; c.alu_src_b = 2'b01; c.pc_write = 1; end
            1:  begin c.alu_src_b = 2'b11; c.illegal = ill; end
            2:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
            4:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            5:  begin c.mem_read = 1; c.iord = 1; end
            6:  begin c.mem_write = 1; c.iord = 1; end
            7:  begin c.reg_write = 1; c.reg_dst = 1; end
            8:  c.reg_write = 1;
            9:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            10: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                      c.pc_source = 2'b01; c.branch_ne = (op == 6'h05); end
            11: begin c.pc_write = 1; c.pc_source = 2'b10; end
            12: begin c.pc_write = 1; c.pc_source = 2'b10; c.jal = 1; end
            13: begin c.pc_write = 1; c.pc_source = 2'b11; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Entered during the low phase with the DUT in IF; leaves at the negedge of the next IF
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit aerr,
                             input string tag);
        int    seq[$];
        int    k;
        bit    counts;
        ctrl_t e, g;
        k = classify(op, fn);
        counts = 1'b1;
        case (k)
            K_R:   seq = '{0, 1, 2, 7};
            K_I:   seq = '{0, 1, 3, 8};
            K_LW:  seq = aerr ? '{0, 1, 4} : '{0, 1, 4, 5, 9};
            K_SW:  seq = aerr ? '{0, 1, 4} : '{0, 1, 4, 6};
            K_BR:  seq = '{0, 1, 10};
            K_J:   seq = '{0, 1, 11};
            K_JAL: seq = '{0, 1, 12};
            K_JR:  seq = '{0, 1, 13};
            default: seq = '{0, 1};
        endcase
        if (k == K_ILL || ((k == K_LW || k == K_SW) && aerr)) counts = 1'b0;
        ctl_if.opcode       = op;
        ctl_if.funct        = fn;
        ctl_if.AddressError = aerr;
        ctl_if.zero         = 1'($urandom_range(0, 1));
        #1;
        foreach (seq[i]) begin
            e = exp_ctrl(seq[i], op, k == K_ILL);
            g = observed();
            n_tests++;
            if (ctl_if.state !== 4'(seq[i]) || g !== e || ctl_if.instr_count !== CW'(model_count)) begin
                n_fail++;
                $display("FAIL %s op=%h fn=%h step %0d: got state=%0d ctrl=%h count=%0d, expected state=%0d ctrl=%h count=%0d",
                         tag, op, fn, i, ctl_if.state, g, ctl_if.instr_count, seq[i], e, model_count);
            end
            @(negedge clk);
        end
        if (counts) model_count = (model_count + 1) % (1 << CW);
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (observed() !== '0 || ctl_if.state !== 4'd0 || ctl_if.instr_count !== '0) begin
            n_fail++;
            $display("FAIL %s: got ctrl=%h state=%0d count=%0d, expected ctrl=0 state=0 count=0",
                     tag, observed(), ctl_if.state, ctl_if.instr_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctl_if.opcode = '0; ctl_if.funct = '0; ctl_if.zero = 1'b0; ctl_if.AddressError = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_hold");
        reset = 1'b0;
        model_count = 0;
    endtask

    task automatic test_alu_ops();
        run_instr(6'h00, 6'h21, 1'b0, "addu");
        run_instr(6'h00, 6'h2a, 1'b0, "slt");
        run_instr(6'h00, 6'h00, 1'b0, "sll");
        run_instr(6'h08, 6'h3f, 1'b0, "addi");
        run_instr(6'h0f, 6'h00, 1'b0, "lui");
    endtask

    task automatic test_load_store();
        run_instr(6'h23, 6'h00, 1'b0, "lw");
        run_instr(6'h23, 6'h00, 1'b1, "lw_addr_err");
        run_instr(6'h2b, 6'h11, 1'b0, "sw");
        run_instr(6'h2b, 6'h11, 1'b1, "sw_addr_err");
    endtask

    task automatic test_control_flow();
        run_instr(6'h03, 6'h00, 1'b0, "jal");
        run_instr(6'h05, 6'h00, 1'b0, "bne");
        run_instr(6'h04, 6'h00, 1'b0, "beq");
        run_instr(6'h02, 6'h00, 1'b0, "j");
        run_instr(6'h00, 6'h08, 1'b0, "jr");
    endtask

    task automatic test_illegal();
        run_instr(6'h3f, 6'h00, 1'b0, "illegal_op3f");
        run_instr(6'h00, 6'h3f, 1'b0, "illegal_funct");
        run_instr(6'h01, 6'h21, 1'b0, "illegal_op01");
    endtask

    task automatic test_reset_mid();
        ctl_if.opcode = 6'h00; ctl_if.funct = 6'h21; ctl_if.AddressError = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (ctl_if.state !== 4'd2) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got state=%0d, expected state=2", ctl_if.state);
        end
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset_mid_async");
        @(negedge clk);
        check_reset_outputs("reset_mid_held");
        reset = 1'b0;
        model_count = 0;
        #1;
        n_tests++;
        if (observed() !== exp_ctrl(0, 6'h00, 1'b0) || ctl_if.state !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got ctrl=%h state=%0d, expected ctrl=%h state=0",
                     observed(), ctl_if.state, exp_ctrl(0, 6'h00, 1'b0));
        end
        run_instr(6'h00, 6'h23, 1'b0, "subu_after_reset");
    endtask

    task automatic test_random();
        logic [5:0] ops [14] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h08, 6'h09, 6'h0c,
                                 6'h0d, 6'h0a, 6'h04, 6'h05, 6'h02, 6'h03, 6'h0f};
        logic [5:0] fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a,
                                 6'h00, 6'h02, 6'h08};
        logic [5:0] op, fn;
        bit         aerr;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            else                           op = ops[$urandom_range(0, 13)];
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            else                           fn = fns[$urandom_range(0, 9)];
            aerr = ($urandom_range(0, 3) == 0);
            run_instr(op, fn, aerr, "random");
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_load_store();
        test_control_flow();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle main control unit for the MIPS-subset CPU. It decodes the latched instruction opcode/funct and steps through fetch/decode/execute/memory/write-back states. It drives the PC, IR, memory, ALU and register-file write controls (RegWrite, RegDst, Mem_to_Reg, jal), so it sits directly upstream of the register file.

Parameters:
RESET_STATE, 4'd0, encoding of IF state entered on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  IR[31:26], stable after IF
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag, valid in BRANCH state
AddressError  input  1  misaligned lw/sw address, valid in MEM_ADDR state
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if branch taken
PCSource  output  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target, 11 rs (jr)
IRWrite  output  1  instruction register load
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable
IorD  output  1  0 address=PC, 1 address=ALUOut
ALUSrcA  output  1  0 PC, 1 rs
ALUSrcB  output  2  00 rt, 01 const 4, 10 sign/zero-ext imm, 11 imm<<2
ALUOp  output  2  00 add, 01 sub, 10 funct-decoded, 11 opcode-decoded (I-type)
RegWrite  output  1  register-file write enable
RegDst  output  1  0 rt, 1 rd
Mem_to_Reg  output  1  0 ALU result, 1 memory data
jal  output  1  write PC+4 to $31
branch_ne  output  1  1 selects bne sense (taken when !zero)
illegal_instr  output  1  one-cycle pulse on unsupported opcode/funct
state  output  4  current state, for debug/bench
instr_count  output  CNT_W  retired-instruction counter

Behaviour:
- State register updates on posedge clk; reset forces state=IF, instr_count=0 immediately.
- While reset is high, every control output is held 0. After release, outputs are Moore functions of state (plus latched opcode/funct for decode-dependent fields).
- States: IF(0), ID(1), EXE_R(2), EXE_I(3), MEM_ADDR(4), MEM_RD(5), MEM_WR(6), WB_R(7), WB_I(8), WB_LW(9), BRANCH(10), JUMP(11), JAL(12), JR(13).
- IF: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=00. Next state is ID.
- ID: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Decode transitions:
  - R-type (000000): funct 001000 (jr) goes to JR. addu/subu/add/sub/and/or/slt/sll/srl go to EXE_R.
  - lw (100011), sw (101011) go to MEM_ADDR.
  - addi/addiu/andi/ori/slti/lui (001xxx subset) go to EXE_I.
  - beq (000100), bne (000101) go to BRANCH.
  - j (000010) goes to JUMP. jal (000011) goes to JAL.
  - Anything else: illegal_instr=1 for this cycle, then IF, no writes.
- EXE_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state WB_R.
- WB_R: RegWrite=1, RegDst=1, Mem_to_Reg=0. Next state IF.
- EXE_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next state WB_I.
- WB_I: RegWrite=1, RegDst=0, Mem_to_Reg=0. Next state IF.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - If AddressError=1, go to IF; the instruction is aborted and not counted.
  - Otherwise lw goes to MEM_RD and sw goes to MEM_WR.
- MEM_RD: MemRead=1, IorD=1. Next state WB_LW.
- WB_LW: RegWrite=1, RegDst=0, Mem_to_Reg=1. Next state IF.
- MEM_WR: MemWrite=1, IorD=1. Next state IF.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, branch_ne=(opcode==bne). Next state IF.
- JUMP: PCWrite=1, PCSource=10. Next state IF.
- JAL: PCWrite=1, PCSource=10, jal=1. Next state IF.
- JR: PCWrite=1, PCSource=11. Next state IF.
- Latencies: branch/j/jal/jr take 3 cycles; R-type, I-type and sw take 4; lw takes 5.
- Overflow suppression is the register file's job; this block asserts RegWrite regardless.
- instr_count increments by 1 on the final state of each completed instruction (WB_*, MEM_WR, BRANCH, JUMP, JAL, JR). It wraps modulo 2^CNT_W. Illegal and aborted instructions do not count.
- Illegal/undefined state encodings (14, 15) go to IF with all outputs 0.
- Reset mid-instruction: the instruction is abandoned and no write strobes are emitted.

Decomposition:
- Shared package mc_cpu_pkg holds:
  - opcode/funct constants;
  - state encodings;
  - ALUOp, PCSource and ALUSrcB encodings;
  - these are shared with the ALU control and datapath.
- One natural sub-module, mc_main_decoder: combinational ID-state next-state/illegal decode from opcode/funct.

Test Plan:
- addu (op 0, funct 100001) after reset: states IF→ID→EXE_R→WB_R→IF. WB_R has RegWrite=1, RegDst=1, Mem_to_Reg=0. instr_count goes 0→1.
- lw, AddressError=0: 5 cycles. MEM_RD has MemRead=1, IorD=1. WB_LW has RegWrite=1, RegDst=0, Mem_to_Reg=1.
- lw with AddressError=1 in MEM_ADDR: returns to IF with no MemRead in the next cycle, RegWrite never asserted, instr_count unchanged.
- jal: 3 cycles. JAL has jal=1, PCWrite=1, PCSource=10. For bne, BRANCH has branch_ne=1 and PCWriteCond=1.
- opcode 111111: illegal_instr pulses in ID, then IF; no write strobes asserted; count unchanged.
- Reset asserted in EXE_R: all outputs 0 asynchronously, state=0, instr_count=0. After release, the first cycle is IF with IRWrite=1.
